// File: rtl/multicycle_control.sv
// Multicycle RV-subset controller: FETCH/DECODE/EXEC sequencing with memory
// wait states, a wait-cycle watchdog and sticky illegal/timeout flags.
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             mem_wait;
    logic             tmo_hit;

    assign tmo_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LIM);

    // State, wait counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and control outputs; everything held at 0 while in reset
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        mem_wait   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ALUOp      = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    mem_wait  = !mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (tmo_hit) begin
                        state_d   = S_HALT;
                        timeout_d = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_LD, OP_SD: state_d = S_MEM_ADDR;
                        OP_R:         state_d = S_EXEC_R;
                        OP_ADDI:      state_d = S_EXEC_I;
                        OP_BEQ:       state_d = S_BRANCH;
                        default: begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_SD) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    mem_wait = !mem_ready;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end else if (tmo_hit) begin
                        state_d   = S_HALT;
                        timeout_d = 1'b1;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    iord     = 1'b1;
                    mem_wait = !mem_ready;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (tmo_hit) begin
                        state_d   = S_HALT;
                        timeout_d = 1'b1;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    ALUOp     = 2'b10;
                    state_d   = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    ALUOp      = 2'b01;
                    pc_src     = 1'b1;
                    pc_write   = zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase

            // Wait counter only runs while a memory state is stalled
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (mem_wait) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: per-instruction
// expected state traces built from instruction class and wait counts.
module tb_multicycle_control;

    localparam int unsigned TO = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3;
    localparam logic [3:0] MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7;
    localparam logic [3:0] ALU_WB = 4'd8, BRANCH = 4'd9, HALT = 4'd10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b, ALUOp;
    logic       reg_write, mem_to_reg;
    logic [3:0] state;
    logic       instr_done, illegal, timeout;

    multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALUOp(ALUOp), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .state(state), .instr_done(instr_done),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       ill;
        logic       tmo;
    } step_t;

    step_t plan[$];
    int    checks = 0;
    int    failures = 0;
    int    exp_retires = 0;
    int    done_seen = 0;

    always @(negedge clk) if (instr_done === 1'b1) done_seen++;

    function automatic logic [19:0] observe();
        return {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, ALUOp, reg_write, mem_to_reg, instr_done, illegal, timeout};
    endfunction

    // Control word each state must present, straight from the state table
    function automatic logic [19:0] expect_out(input logic [3:0] st, input logic rdy,
                                               input logic z, input logic ill, input logic tmo);
        logic mreq, mwe, io, irw, pcw, pcs, asa, rw, m2r, done;
        logic [1:0] asb, aop;
        {mreq, mwe, io, irw, pcw, pcs, asa, rw, m2r, done} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (st)
            FETCH:     begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE:    asb = 2'b10;
            MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            MEM_READ:  begin mreq = 1; io = 1; end
            MEM_WB:    begin rw = 1; m2r = 1; done = 1; end
            MEM_WRITE: begin mreq = 1; mwe = 1; io = 1; done = rdy; end
            EXEC_R:    begin asa = 1; aop = 2'b10; end
            EXEC_I:    begin asa = 1; asb = 2'b10; end
            ALU_WB:    begin rw = 1; done = 1; end
            BRANCH:    begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; done = 1; end
            default:   ;
        endcase
        return {st, mreq, mwe, io, irw, pcw, pcs, asa, asb, aop, rw, m2r, done, ill, tmo};
    endfunction

    function automatic int latency(input logic [6:0] op, input int wf, input int wm);
        int base;
        base = (op == OP_BEQ) ? 3 : (op == OP_LD) ? 5 : 4;
        return base + wf + (((op == OP_LD) || (op == OP_SD)) ? wm : 0);
    endfunction

    task automatic add(input logic [3:0] st, input logic rdy, input logic ill, input logic tmo);
        step_t s;
        s.st = st; s.rdy = rdy; s.ill = ill; s.tmo = tmo;
        plan.push_back(s);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace for one instruction
    task automatic plan_instr(input logic [6:0] op, input int wf, input int wm);
        plan.delete();
        repeat (wf) add(FETCH, 1'b0, 1'b0, 1'b0);
        add(FETCH, 1'b1, 1'b0, 1'b0);
        add(DECODE, rnd(), 1'b0, 1'b0);
        case (op)
            OP_R:    begin add(EXEC_R, rnd(), 0, 0); add(ALU_WB, rnd(), 0, 0); end
            OP_ADDI: begin add(EXEC_I, rnd(), 0, 0); add(ALU_WB, rnd(), 0, 0); end
            OP_LD: begin
                add(MEM_ADDR, rnd(), 0, 0);
                repeat (wm) add(MEM_READ, 1'b0, 0, 0);
                add(MEM_READ, 1'b1, 0, 0);
                add(MEM_WB, rnd(), 0, 0);
            end
            OP_SD: begin
                add(MEM_ADDR, rnd(), 0, 0);
                repeat (wm) add(MEM_WRITE, 1'b0, 0, 0);
                add(MEM_WRITE, 1'b1, 0, 0);
            end
            OP_BEQ:  add(BRANCH, rnd(), 0, 0);
            default: repeat (20) add(HALT, rnd(), 1'b1, 1'b0);
        endcase
    endtask

    // Starts just after a rising edge; drives mem_ready, samples at the falling edge
    task automatic run_plan(input string name, input logic z, input int n, input int lat_exp);
        step_t e;
        logic [19:0] got, exp;
        int first_done;
        first_done = -1;
        for (int i = 0; i < n; i++) begin
            e = plan[i];
            mem_ready = e.rdy;
            zero = z;
            @(negedge clk);
            got = observe();
            exp = expect_out(e.st, e.rdy, z, e.ill, e.tmo);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s cycle %0d: got %05h expected %05h", name, i, got, exp);
            end
            if (instr_done === 1'b1 && first_done < 0) first_done = i;
            @(posedge clk);
            #1;
        end
        if (lat_exp > 0) begin
            exp_retires++;
            checks++;
            if (first_done + 1 != lat_exp) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", name, first_done + 1, lat_exp);
            end
        end
    endtask

    task automatic do_instr(input string name, input logic [6:0] op, input logic z,
                            input int wf, input int wm);
        opcode = op;
        plan_instr(op, wf, wm);
        run_plan(name, z, plan.size(), latency(op, wf, wm));
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        mem_ready = rnd();
        #1;
        checks++;
        if (observe() !== 20'h0) begin
            failures++;
            $display("FAIL %s in_reset: got %05h expected 00000", name, observe());
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state, mem_req, illegal, timeout} !== {FETCH, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s after_release: got st=%0d req=%b ill=%b tmo=%b expected st=0 req=1 ill=0 tmo=0",
                     name, state, mem_req, illegal, timeout);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_r_type();
        do_instr("r_type", OP_R, 1'b0, 0, 0);
        do_instr("addi", OP_ADDI, 1'b1, 0, 0);
    endtask

    task automatic test_load_wait();
        do_instr("ld_wait3", OP_LD, 1'b0, 0, 3);
        do_instr("sd_wait2", OP_SD, 1'b0, 1, 2);
    endtask

    task automatic test_branch();
        do_instr("beq_taken", OP_BEQ, 1'b1, 0, 0);
        do_instr("beq_not_taken", OP_BEQ, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops[5];
        ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_LD; ops[3] = OP_SD; ops[4] = OP_BEQ;
        for (int k = 0; k < 30; k++) begin
            do_instr("random", ops[$urandom_range(0, 4)], rnd(),
                     int'($urandom_range(0, TO)), int'($urandom_range(0, TO)));
        end
    endtask

    task automatic test_timeout_boundary();
        do_instr("fetch_ready_at_limit", OP_R, 1'b0, TO, 0);
        do_instr("read_ready_at_limit", OP_LD, 1'b0, 0, TO);
        do_instr("write_ready_at_limit", OP_SD, 1'b0, 0, TO);
    endtask

    task automatic test_timeout();
        opcode = OP_R;
        plan.delete();
        repeat (TO + 1) add(FETCH, 1'b0, 1'b0, 1'b0);
        repeat (6) add(HALT, rnd(), 1'b0, 1'b1);
        run_plan("fetch_timeout", 1'b0, plan.size(), 0);
        do_reset("timeout_clear");
    endtask

    task automatic test_illegal();
        opcode = OP_BAD;
        plan_instr(OP_BAD, 0, 0);
        run_plan("illegal", 1'b0, plan.size(), 0);
        do_reset("illegal_clear");
    endtask

    task automatic test_reset_mid();
        opcode = OP_SD;
        plan_instr(OP_SD, 0, 3);
        run_plan("sd_abort", 1'b0, 4, 0);
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, mem_req, mem_we} !== {MEM_WRITE, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sd_abort pre_reset: got st=%0d req=%b we=%b expected st=5 req=1 we=1",
                     state, mem_req, mem_we);
        end
        do_reset("sd_abort");
        do_instr("after_abort", OP_R, 1'b0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = OP_R;
        zero = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_branch();
        test_random();
        test_timeout_boundary();
        test_timeout();
        test_illegal();
        test_reset_mid();
        checks++;
        if (done_seen != exp_retires) begin
            failures++;
            $display("FAIL retire_count: got %0d expected %0d", done_seen, exp_retires);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
